// File: rtl/nes_bus_pkg.sv
// Shared NES CPU bus definitions: DMA sequencer states and the fixed
// register/range addresses used by the OAM DMA block and the bus decoder.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  // Individual register addresses
  localparam logic [15:0] PPU_OAMDATA_ADDR = 16'h2004;
  localparam logic [15:0] OAM_DMA_ADDR     = 16'h4014;
  localparam logic [15:0] JOY1_ADDR        = 16'h4016;
  localparam logic [15:0] JOY2_ADDR        = 16'h4017;

  // Decoder ranges: PPU registers mirror across $2000-$3FFF, cartridge from $4020
  localparam logic [15:0] PPU_REG_BASE     = 16'h2000;
  localparam logic [15:0] PPU_REG_END      = 16'h3FFF;
  localparam logic [15:0] CART_BASE        = 16'h4020;

  // Source address of one DMA byte: fixed page, 8-bit index with no carry
  function automatic logic [15:0] dma_src_addr(input logic [7:0] page,
                                               input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA sequencer. A CPU write to DMA_REG_ADDR halts the CPU via
// cpu_rdy, then copies 256 bytes from page $XX00-$XXFF to OAM_DATA_ADDR with
// alternating get (read) and put (write) CPU cycles. All sequencing advances
// on cpu_ce only; dma_done is the sole output that changes between pulses.
// Build option: define NES_DMA_ALIGN_EN to track get/put parity and insert
// one ALIGN cycle when the first read would land on a put cycle (513/514
// cycles). Without it, HALT always proceeds straight to READ (513 cycles).
module nes_oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = OAM_DMA_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = PPU_OAMDATA_ADDR,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic [7:0]  dma_wdata,
  output logic        dma_done
);

  // Index of the final byte; the index counter is 8 bits so XFER_LEN is 256
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        active_q, active_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic        trigger;

`ifdef NES_DMA_ALIGN_EN
  logic        parity_q;  // 0 = current CPU cycle is a get, 1 = put

  // Get/put parity flips on every CPU cycle from reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else if (cpu_ce) begin
      parity_q <= ~parity_q;
    end
  end
`endif

  assign trigger = cpu_wr && (cpu_addr == DMA_REG_ADDR);

  // Next-state and next-output logic; outputs are registered so they hold
  // for the whole CPU cycle that the new state occupies
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    active_d = active_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    done_d   = 1'b0;

    if (cpu_ce) begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            page_d  = cpu_dout;
            idx_d   = '0;
            rdy_d   = 1'b0;
            state_d = HALT;
          end
        end

        HALT: begin
          // The CPU only stalls on a read; keep waiting while it still writes
          if (cpu_rd) begin
            active_d = 1'b1;
`ifdef NES_DMA_ALIGN_EN
            // Next cycle is a put when the current one is a get
            if (!parity_q) begin
              state_d = ALIGN;
            end else begin
              state_d = READ;
              rd_d    = 1'b1;
              addr_d  = dma_src_addr(page_q, idx_q);
            end
`else
            state_d = READ;
            rd_d    = 1'b1;
            addr_d  = dma_src_addr(page_q, idx_q);
`endif
          end
        end

        ALIGN: begin
          state_d = READ;
          rd_d    = 1'b1;
          addr_d  = dma_src_addr(page_q, idx_q);
        end

        READ: begin
          data_d  = bus_rdata;
          state_d = WRITE;
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          addr_d  = OAM_DATA_ADDR;
        end

        WRITE: begin
          wr_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d  = IDLE;
            rdy_d    = 1'b1;
            active_d = 1'b0;
            done_d   = 1'b1;
            addr_d   = '0;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = READ;
            rd_d    = 1'b1;
            addr_d  = dma_src_addr(page_q, idx_q + 8'd1);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; without cpu_ce the next values equal the
  // current ones, so everything except the dma_done pulse holds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
    end
  end

  assign cpu_rdy    = rdy_q;
  assign dma_active = active_q;
  assign dma_addr   = addr_q;
  assign dma_rd     = rd_q;
  assign dma_wr     = wr_q;
  assign dma_wdata  = data_q;
  assign dma_done   = done_q;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Self-checking bench for nes_oam_dma: table of transfer scenarios plus a
// table of non-triggering bus accesses, and a hand-written mid-transfer
// reset/restart sequence. Honours NES_DMA_ALIGN_EN for expected cycle counts.
module tb_nes_oam_dma;
  import nes_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        dma_wr;
  logic [7:0]  dma_wdata;
  logic        dma_done;

  logic [7:0]  mem [0:65535];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned ce_total = 0;
  bit          last_done;
  bit          mon_on = 1'b0;
  logic [7:0]  mon_page;
  int unsigned rd_cnt, rd_err, wr_err, align_cnt, stab_err;
  logic [7:0]  wq [$];

  nes_oam_dma #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004),
    .XFER_LEN     (256)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_ce    (cpu_ce),
    .cpu_addr  (cpu_addr),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_dout  (cpu_dout),
    .bus_rdata (bus_rdata),
    .cpu_rdy   (cpu_rdy),
    .dma_active(dma_active),
    .dma_addr  (dma_addr),
    .dma_rd    (dma_rd),
    .dma_wr    (dma_wr),
    .dma_wdata (dma_wdata),
    .dma_done  (dma_done)
  );

  always #5 clk = ~clk;

  // Decoder model: DMA owns the bus while active
  assign bus_rdata = mem[dma_active ? dma_addr : cpu_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One CPU cycle: inputs set at negedge, optional idle clocks, then a ce pulse
  task automatic do_ce(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [7:0] dout, input int unsigned gap);
    logic [27:0] snap;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_dout = dout;
    snap = {cpu_rdy, dma_active, dma_addr, dma_rd, dma_wr, dma_wdata};
    for (int unsigned g = 0; g < gap; g++) begin
      @(posedge clk); @(negedge clk);
      if ({cpu_rdy, dma_active, dma_addr, dma_rd, dma_wr, dma_wdata} !== snap) stab_err++;
    end
    if (mon_on) begin
      if (dma_wr) begin
        if (dma_addr !== 16'h2004) wr_err++;
        wq.push_back(dma_wdata);
      end
      if (dma_rd) begin
        if (dma_addr !== {mon_page, 8'(rd_cnt)}) rd_err++;
        rd_cnt++;
      end
      if (dma_active && !dma_rd && !dma_wr) align_cnt++;
    end
    cpu_ce = 1'b1;
    @(posedge clk); @(negedge clk);
    cpu_ce = 1'b0;
    ce_total++;
    last_done = dma_done;
  endtask

  task automatic run_xfer(input logic [7:0] page, input bit odd, input int unsigned extra,
                          input bit gaps, input int unsigned stop_at,
                          output int unsigned ce_cnt, output bit done);
    bit first;
    if ((ce_total % 2) != 32'(odd)) do_ce(1'b1, 1'b0, 16'h8000, 8'h00, 0);
    wq.delete();
    rd_cnt = 0; rd_err = 0; wr_err = 0; align_cnt = 0; stab_err = 0;
    mon_page = page;
    do_ce(1'b0, 1'b1, 16'h4014, page, 0);
    chk("rdy_low_after_trigger", 32'(cpu_rdy), 32'd0);
    mon_on = 1'b1;
    ce_cnt = 0; done = 1'b0; first = 1'b1;
    // CPU still finishing writes (to $4014 again: must not relatch the page)
    for (int unsigned k = 0; k < extra; k++) begin
      chk("active_during_cpu_write", 32'(dma_active), 32'd0);
      do_ce(1'b0, 1'b1, 16'h4014, 8'h07, gaps ? $urandom_range(0, 4) : 0);
      ce_cnt++;
    end
    chk("active_before_dummy_read", 32'(dma_active), 32'd0);
    while (!done && ce_cnt < 700 && (stop_at == 0 || wq.size() < stop_at)) begin
      do_ce(1'b1, 1'b0, 16'h8000, 8'h00, gaps ? $urandom_range(0, 4) : 0);
      ce_cnt++;
      done = last_done;
      if (first) begin
        chk("active_after_dummy_read", 32'(dma_active), 32'd1);
        first = 1'b0;
      end
    end
    mon_on = 1'b0;
  endtask

  task automatic check_full(input string tag, input logic [7:0] page, input bit done,
                            input int unsigned ce_cnt, input int unsigned exp_ce,
                            input int unsigned exp_align);
    int unsigned byte_err;
    logic [7:0]  iv;
    byte_err = 0;
    for (int unsigned i = 0; i < wq.size(); i++) begin
      iv = 8'(i);
      if (wq[i] !== mem[{page, iv}]) byte_err++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_ce_count"}, ce_cnt, exp_ce);
    chk({tag, "_write_count"}, wq.size(), 32'd256);
    chk({tag, "_byte_errors"}, byte_err, 32'd0);
    chk({tag, "_wr_addr_errors"}, wr_err, 32'd0);
    chk({tag, "_rd_addr_errors"}, rd_err, 32'd0);
    chk({tag, "_read_count"}, rd_cnt, 32'd256);
    chk({tag, "_align_cycles"}, align_cnt, exp_align);
    chk({tag, "_gap_stability"}, stab_err, 32'd0);
    chk({tag, "_rdy_after"}, 32'(cpu_rdy), 32'd1);
    chk({tag, "_active_after"}, 32'(dma_active), 32'd0);
    chk({tag, "_strobes_after"}, {30'd0, dma_rd, dma_wr}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  page;
    bit          odd;
    int unsigned extra;
    bit          gaps;
    int unsigned exp_ce;
    int unsigned exp_align;
  } xfer_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        exp_rdy;
  } vec_t;

  initial begin
    xfer_t       xt [5];
    vec_t        vt [5];
    int unsigned ce_cnt;
    bit          done;

    for (int unsigned a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int unsigned i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i);
      mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
      mem[16'h0700 + i] = 8'hEE;
    end

`ifdef NES_DMA_ALIGN_EN
    xt[0] = '{8'h02, 1'b0, 0, 1'b0, 513, 0};
    xt[1] = '{8'h02, 1'b1, 0, 1'b0, 514, 1};
    xt[2] = '{8'h02, 1'b0, 2, 1'b0, 515, 0};
    xt[3] = '{8'h02, 1'b1, 0, 1'b1, 514, 1};
    xt[4] = '{8'h02, 1'b0, 1, 1'b1, 515, 1};
`else
    xt[0] = '{8'h02, 1'b0, 0, 1'b0, 513, 0};
    xt[1] = '{8'h02, 1'b1, 0, 1'b0, 513, 0};
    xt[2] = '{8'h02, 1'b0, 2, 1'b0, 515, 0};
    xt[3] = '{8'h02, 1'b1, 0, 1'b1, 513, 0};
    xt[4] = '{8'h02, 1'b0, 1, 1'b1, 514, 0};
`endif

    vt[0] = '{1'b0, 1'b1, 16'h4015, 8'h02, 1'b1};
    vt[1] = '{1'b0, 1'b1, 16'h4013, 8'h02, 1'b1};
    vt[2] = '{1'b1, 1'b0, 16'h4014, 8'h02, 1'b1};
    vt[3] = '{1'b0, 1'b1, 16'h4016, 8'h02, 1'b1};
    vt[4] = '{1'b1, 1'b0, 16'h2004, 8'h00, 1'b1};

    reset_n = 1'b0; cpu_ce = 1'b0; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_dout = '0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", 32'(cpu_rdy), 32'd1);
    chk("reset_active", 32'(dma_active), 32'd0);
    chk("reset_addr", 32'(dma_addr), 32'd0);
    chk("reset_strobes_done", {29'd0, dma_rd, dma_wr, dma_done}, 32'd0);
    chk("reset_wdata", 32'(dma_wdata), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Non-triggering accesses
    for (int unsigned v = 0; v < 5; v++) begin
      do_ce(vt[v].rd, vt[v].wr, vt[v].addr, vt[v].dout, 0);
      chk("notrig_rdy", 32'(cpu_rdy), 32'(vt[v].exp_rdy));
      chk("notrig_active", 32'(dma_active), 32'd0);
    end
    do_ce(1'b1, 1'b0, 16'h8000, 8'h00, 0);
    chk("notrig_no_read", 32'(dma_rd), 32'd0);

    // Transfer scenarios
    for (int unsigned t = 0; t < 5; t++) begin
      run_xfer(xt[t].page, xt[t].odd, xt[t].extra, xt[t].gaps, 0, ce_cnt, done);
      check_full($sformatf("xfer%0d", t), xt[t].page, done, ce_cnt, xt[t].exp_ce, xt[t].exp_align);
    end

    // Reset when idx reaches $80, then restart from page $03
    run_xfer(8'h02, 1'b0, 0, 1'b0, 128, ce_cnt, done);
    chk("abort_reached_idx80", wq.size(), 32'd128);
    chk("abort_rd_at_idx80", {16'd0, dma_addr}, 32'h0280);
    reset_n = 1'b0;
    #1;
    chk("abort_rdy", 32'(cpu_rdy), 32'd1);
    chk("abort_active", 32'(dma_active), 32'd0);
    chk("abort_strobes", {30'd0, dma_rd, dma_wr}, 32'd0);
    chk("abort_addr", 32'(dma_addr), 32'd0);
    ce_total = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_xfer(8'h03, 1'b0, 0, 1'b0, 0, ce_cnt, done);
    check_full("restart", 8'h03, done, ce_cnt, 513, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
